// File: rtl/amiga_clk_pkg.sv
// Shared defaults and configuration checks for the 28 MHz clock-enable generator.
// Parameters are validated at elaboration so a bad E-clock modulus never reaches silicon.
package amiga_clk_pkg;

    localparam int PH_W_DEF  = 2;
    localparam int E_DIV_PAL = 10;
    localparam int E_W_DEF   = 4;

    // E_DIV must be even, at least 2, and representable in E_W bits
    function automatic bit cfg_ok(input int e_div, input int e_w);
        return (e_div >= 32'sd2) && ((e_div % 32'sd2) == 32'sd0) && (e_w >= $clog2(e_div));
    endfunction

endpackage

// File: rtl/amiga_mod_cnt.sv
// Modulus-MOD counter with enable and synchronous clear.
// Any out-of-range value is pulled back to 0 on the next enabled step.
module amiga_mod_cnt #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_r;

    // counter register: clear dominates, wrap at MOD-1
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            if (cnt_r >= LAST) begin
                cnt_r <= {W{1'b0}};
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/amiga_clken_gen.sv
// Clock-enable generator for the 28 MHz domain: base-rate enables, C1/C3 phase
// signals, colour clock and one-hot E-clock phase, with lock, freeze and resync.
module amiga_clken_gen
    import amiga_clk_pkg::*;
#(
    parameter int PH_W  = PH_W_DEF,
    parameter int E_DIV = E_DIV_PAL,
    parameter int E_W   = E_W_DEF
) (
    input  logic             clk_28,
    input  logic             rst,
    input  logic             locked,
    input  logic             run,
    input  logic             resync,
    output logic             clk7_en,
    output logic             clk7n_en,
    output logic             c1,
    output logic             c3,
    output logic             cck,
    output logic [E_DIV-1:0] eclk,
    output logic [PH_W-1:0]  phase,
    output logic [E_W-1:0]   e_cnt
);

    localparam logic [PH_W-1:0] HALF = PH_W'(32'd1 << (PH_W - 1));

    if (!cfg_ok(E_DIV, E_W) || (PH_W < 2)) begin : g_cfg_err
        $error("amiga_clken_gen: illegal PH_W/E_DIV/E_W combination");
    end

    logic [PH_W-1:0]  ph_r;
    logic             clk7_en_r;
    logic             clk7n_en_r;
    logic             c1_r;
    logic             c3_r;
    logic             clk_7_s;
    logic             clr_s;
    logic             cnt_en_s;
    logic [E_W-1:0]   e_cnt_s;
    logic [E_DIV-1:0] eclk_s;

    assign clk_7_s  = ph_r[PH_W-1];
    assign clr_s    = rst | ~locked;
    // resync suppresses the E advance even when it lands on ph == 1
    assign cnt_en_s = run & ~resync & (ph_r == PH_W'(1));

    // phase counter, enables and C1/C3, in priority rst/lock > resync > freeze > run
    always_ff @(posedge clk_28) begin
        if (clr_s) begin
            ph_r       <= HALF;
            clk7_en_r  <= 1'b1;
            clk7n_en_r <= 1'b1;
            c1_r       <= 1'b0;
            c3_r       <= 1'b0;
        end else if (resync) begin
            ph_r       <= {PH_W{1'b0}};
            clk7_en_r  <= 1'b0;
            clk7n_en_r <= 1'b0;
            c3_r       <= clk_7_s;
            c1_r       <= ~c3_r;
        end else if (!run) begin
            ph_r       <= ph_r;
            clk7_en_r  <= 1'b0;
            clk7n_en_r <= 1'b0;
            c1_r       <= c1_r;
            c3_r       <= c3_r;
        end else begin
            ph_r       <= ph_r + PH_W'(1);
            clk7_en_r  <= (ph_r == {PH_W{1'b0}});
            clk7n_en_r <= (ph_r == HALF);
            c3_r       <= clk_7_s;
            c1_r       <= ~c3_r;
        end
    end

    amiga_mod_cnt #(
        .MOD (E_DIV),
        .W   (E_W)
    ) u_e_cnt (
        .clk (clk_28),
        .clr (clr_s),
        .en  (cnt_en_s),
        .cnt (e_cnt_s)
    );

    // one-hot E phase decode of the registered counter
    always_comb begin
        eclk_s = {E_DIV{1'b0}};
        for (int i = 0; i < E_DIV; i++) begin
            eclk_s[i] = (e_cnt_s == E_W'(i));
        end
    end

    assign clk7_en  = clk7_en_r;
    assign clk7n_en = clk7n_en_r;
    assign c1       = c1_r;
    assign c3       = c3_r;
    assign phase    = ph_r;
    assign e_cnt    = e_cnt_s;
    assign eclk     = eclk_s;
    assign cck      = ~e_cnt_s[0];

endmodule

// File: tb/tb_amiga_clken_gen.sv
// Scoreboard bench for amiga_clken_gen: default (PH_W=2,E_DIV=10) and PH_W=3,E_DIV=6 instances.
module tb_amiga_clken_gen;

    typedef struct {
        int id;
        int ph;
        bit en;
        bit nen;
        bit c1;
        bit c3;
        int ec;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b1;
    logic run = 1'b1;
    logic resync = 1'b0;

    logic       en0, nen0, c1_0, c3_0, cck0;
    logic [9:0] eclk0;
    logic [1:0] phase0;
    logic [3:0] ecnt0;
    logic       en1, nen1, c1_1, c3_1, cck1;
    logic [5:0] eclk1;
    logic [2:0] phase1;
    logic [2:0] ecnt1;

    int n_vec = 0;
    int n_bad = 0;
    ent_t sb[$];
    ent_t m0, m1, me;

    always #5 clk = ~clk;

    amiga_clken_gen u_dut0 (
        .clk_28(clk), .rst(rst), .locked(locked), .run(run), .resync(resync),
        .clk7_en(en0), .clk7n_en(nen0), .c1(c1_0), .c3(c3_0), .cck(cck0),
        .eclk(eclk0), .phase(phase0), .e_cnt(ecnt0)
    );

    amiga_clken_gen #(.PH_W(3), .E_DIV(6), .E_W(3)) u_dut1 (
        .clk_28(clk), .rst(rst), .locked(locked), .run(run), .resync(resync),
        .clk7_en(en1), .clk7n_en(nen1), .c1(c1_1), .c3(c3_1), .cck(cck1),
        .eclk(eclk1), .phase(phase1), .e_cnt(ecnt1)
    );

    // Reference behaviour of one clock edge
    function automatic ent_t step(ent_t s, bit r, bit lk, bit rn, bit rs, int phw, int ediv);
        int p = 1 << phw;
        int h = p / 2;
        ent_t n = s;
        if (r || !lk) begin
            n.ph = h; n.en = 1; n.nen = 1; n.c1 = 0; n.c3 = 0; n.ec = 0;
        end else if (rs) begin
            n.ph = 0; n.en = 0; n.nen = 0; n.c3 = (s.ph >= h); n.c1 = !s.c3;
        end else if (!rn) begin
            n.en = 0; n.nen = 0;
        end else begin
            n.ph = (s.ph + 1) % p;
            n.en = (s.ph == 0);
            n.nen = (s.ph == h);
            n.c3 = (s.ph >= h);
            n.c1 = !s.c3;
            if (s.ph == 1) n.ec = (s.ec == ediv - 1) ? 0 : s.ec + 1;
        end
        return n;
    endfunction

    task automatic chk(string name, int id, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] t=%0t got %0d want %0d", name, id, $time, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation against the presented outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.id == 0) begin
                chk("phase", 0, int'(phase0), me.ph);
                chk("clk7_en", 0, int'(en0), int'(me.en));
                chk("clk7n_en", 0, int'(nen0), int'(me.nen));
                chk("c1", 0, int'(c1_0), int'(me.c1));
                chk("c3", 0, int'(c3_0), int'(me.c3));
                chk("e_cnt", 0, int'(ecnt0), me.ec);
                chk("cck", 0, int'(cck0), (me.ec % 2 == 0) ? 1 : 0);
                chk("eclk", 0, int'(eclk0), 1 << me.ec);
            end else begin
                chk("phase", 1, int'(phase1), me.ph);
                chk("clk7_en", 1, int'(en1), int'(me.en));
                chk("clk7n_en", 1, int'(nen1), int'(me.nen));
                chk("c1", 1, int'(c1_1), int'(me.c1));
                chk("c3", 1, int'(c3_1), int'(me.c3));
                chk("e_cnt", 1, int'(ecnt1), me.ec);
                chk("cck", 1, int'(cck1), (me.ec % 2 == 0) ? 1 : 0);
                chk("eclk", 1, int'(eclk1), 1 << me.ec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        m0 = step(m0, rst, locked, run, resync, 2, 10);
        m1 = step(m1, rst, locked, run, resync, 3, 6);
        sb.push_back(m0);
        sb.push_back(m1);
        #1;
    endtask

    // Like tick(), but instance 0 is checked against hand-written values
    task automatic tick_tbl(int ph, bit en, bit nen, bit c1v, bit c3v, int ec);
        ent_t t;
        @(posedge clk);
        m0 = step(m0, rst, locked, run, resync, 2, 10);
        m1 = step(m1, rst, locked, run, resync, 3, 6);
        t.id = 0; t.ph = ph; t.en = en; t.nen = nen; t.c1 = c1v; t.c3 = c3v; t.ec = ec;
        sb.push_back(t);
        sb.push_back(m1);
        #1;
    endtask

    task automatic post_release_table();
        int t_ph[5]  = '{3, 0, 1, 2, 3};
        bit t_en[5]  = '{0, 0, 1, 0, 0};
        bit t_nen[5] = '{1, 0, 0, 0, 1};
        bit t_c1[5]  = '{1, 0, 0, 1, 1};
        bit t_c3[5]  = '{1, 1, 0, 0, 1};
        int t_ec[5]  = '{0, 0, 0, 1, 1};
        for (int k = 0; k < 5; k++) tick_tbl(t_ph[k], t_en[k], t_nen[k], t_c1[k], t_c3[k], t_ec[k]);
    endtask

    task automatic tick_until_ph1();
        for (int k = 0; k < 16 && m0.ph != 1; k++) tick();
    endtask

    initial begin
        m0 = '{0, 0, 0, 0, 0, 0, 0};
        m1 = '{1, 0, 0, 0, 0, 0, 0};
        #1;
        // reset held for three edges, then the documented release sequence
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick_tbl(2, 1, 1, 0, 0, 0);
        rst = 1'b0;
        post_release_table();
        // steady state covering several E-clock wraps on both instances
        for (int k = 0; k < 200; k++) tick();
        // freeze for 7 edges at ph == 1, then resume
        tick_until_ph1();
        run = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        run = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        // single-cycle resync at ph == 1
        tick_until_ph1();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        // three-cycle resync
        resync = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        resync = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        // one-cycle lock drop at e_cnt == 5, recovery must match reset release
        for (int k = 0; k < 100 && m0.ec != 5; k++) tick();
        locked = 1'b0;
        tick_tbl(2, 1, 1, 0, 0, 0);
        locked = 1'b1;
        post_release_table();
        // fresh reset, then long run for the PH_W=3 / E_DIV=6 wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 120; k++) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
